// File: rtl/cost_grad_engine_pkg.sv
// gdo: shared FSM state type and saturating arithmetic helpers for cost_grad_engine.
// Helpers take a target width w and clamp to the signed w-bit range, so one
// set of functions serves both the data_size lane math and the wider loss sum.
package gdo;
  typedef enum logic [1:0] {IDLE, COMPUTE, HOLD} state_t;
  function automatic longint gdo_sat(input longint v, input int w);
    longint mx, mn;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    return v > mx ? mx : v < mn ? mn : v;
  endfunction
  function automatic longint gdo_sub(input longint a, input longint b, input int w);
    return gdo_sat(a - b, w);
  endfunction
  function automatic longint gdo_add(input longint a, input longint b, input int w);
    return gdo_sat(a + b, w);
  endfunction
  function automatic longint gdo_mult(input longint a, input longint b, input int sh, input int w);
    return gdo_sat((a * b) >>> sh, w);
  endfunction
endpackage

// File: rtl/cost_grad_engine_lane.sv
// cost_grad_lane: per-channel error, gradient and squared-error term (combinational).
// Ports: p, z -- prediction/target; mode -- 0 squared, 1 sign gradient;
//        grad -- gradient; sq -- saturated (e*e) >> data_size/2.
module cost_grad_lane
  import gdo::*;
#(
  parameter int data_size = 16
) (
  input  logic signed [data_size-1:0] p,
  input  logic signed [data_size-1:0] z,
  input  logic                        mode,
  output logic signed [data_size-1:0] grad,
  output logic signed [data_size-1:0] sq
);
  localparam logic signed [data_size-1:0] one = data_size'(1) << (data_size / 2);
  logic signed [data_size-1:0] e;
  always_comb begin
    e    = data_size'(gdo_sub(longint'(p), longint'(z), data_size));
    grad = mode ? (e < 0 ? one : e > 0 ? -one : '0)
                : data_size'(gdo_mult(longint'(e), -64'sd2, 0, data_size));
    sq   = data_size'(gdo_mult(longint'(e), longint'(e), data_size / 2, data_size));
  end
endmodule

// File: rtl/cost_grad_engine.sv
// cost_grad_engine: sequential per-sample cost gradient and squared-error loss.
// Ports: clk, reset_n (async active-low); predict_value, z, mode, in_valid/in_ready
//        accept a sample; diff, loss, out_valid/out_ready return the result.
// One shared lane walks the channels, one per cycle, then the result is held.
module cost_grad_engine
  import gdo::*;
#(
  parameter int size      = 3,
  parameter int data_size = 16,
  parameter int loss_size = data_size + $clog2(size) + 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [size*data_size-1:0] predict_value,
  input  logic [size*data_size-1:0] z,
  input  logic                      mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [size*data_size-1:0] diff,
  output logic [loss_size-1:0]      loss,
  output logic                      out_valid,
  input  logic                      out_ready
);
  localparam int iw = $clog2(size + 1);
  state_t state, state_nx;
  logic [size*data_size-1:0] p_r, z_r;
  logic mode_r;
  logic [iw-1:0] idx;
  logic signed [data_size-1:0] p_ch, z_ch, grad, sq;
  logic last;
  always_comb begin
    p_ch = '0;
    z_ch = '0;
    for (int i = 0; i < size; i++) begin
      if (int'(idx) == i) begin
        p_ch = p_r[(size-1-i)*data_size +: data_size];
        z_ch = z_r[(size-1-i)*data_size +: data_size];
      end
    end
  end
  cost_grad_lane #(.data_size(data_size)) lane (
    .p(p_ch), .z(z_ch), .mode(mode_r), .grad(grad), .sq(sq)
  );
  always_comb begin
    last      = int'(idx) == size - 1;
    in_ready  = state == IDLE;
    out_valid = state == HOLD;
    state_nx  = state == IDLE    ? (in_valid ? COMPUTE : IDLE) :
                state == COMPUTE ? (last ? HOLD : COMPUTE) :
                                   (out_ready ? IDLE : HOLD);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      idx    <= '0;
      diff   <= '0;
      loss   <= '0;
      p_r    <= '0;
      z_r    <= '0;
      mode_r <= 1'b0;
    end else begin
      state <= state_nx;
      if (in_valid && in_ready) begin
        p_r    <= predict_value;
        z_r    <= z;
        mode_r <= mode;
        idx    <= '0;
        diff   <= '0;
        loss   <= '0;
      end else if (state == COMPUTE) begin
        for (int i = 0; i < size; i++)
          if (int'(idx) == i) diff[(size-1-i)*data_size +: data_size] <= grad;
        loss <= loss_size'(gdo_add(longint'($signed(loss)), longint'(sq), loss_size));
        idx  <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cost_grad_engine.sv
// tb_cost_grad_engine: directed and randomized checks of cost_grad_engine against a reference model.
module tb_cost_grad_engine;
  localparam int SZ = 3, DW = 16, LW = 19;
  logic clk = 0, reset_n = 0, mode_in = 0, in_valid = 0, out_ready = 0;
  logic [SZ*DW-1:0] predict_value = '0, z_in = '0, diff;
  logic [LW-1:0] loss;
  logic in_ready, out_valid;
  int total = 0, passed = 0;

  cost_grad_engine dut (
    .clk(clk), .reset_n(reset_n), .predict_value(predict_value), .z(z_in),
    .mode(mode_in), .in_valid(in_valid), .in_ready(in_ready), .diff(diff),
    .loss(loss), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return v < lo ? lo : v > hi ? hi : v;
  endfunction

  function automatic void model(input logic [SZ*DW-1:0] p, input logic [SZ*DW-1:0] zz,
                                input logic m, output logic [SZ*DW-1:0] d,
                                output logic [LW-1:0] l);
    int acc = 0;
    d = '0;
    for (int i = 0; i < SZ; i++) begin
      logic signed [DW-1:0] pw, zw;
      int e, g, s;
      pw = p[(SZ-i)*DW-1 -: DW];
      zw = zz[(SZ-i)*DW-1 -: DW];
      e = clamp(int'(pw) - int'(zw), -32768, 32767);
      g = m ? (e < 0 ? 256 : e > 0 ? -256 : 0) : clamp(-2 * e, -32768, 32767);
      s = clamp((e * e) / 256, -32768, 32767);
      d[(SZ-i)*DW-1 -: DW] = DW'(g);
      acc = clamp(acc + s, -(1 << (LW - 1)), (1 << (LW - 1)) - 1);
    end
    l = LW'(acc);
  endfunction

  task automatic run_sample(input logic [SZ*DW-1:0] p, input logic [SZ*DW-1:0] zz,
                            input logic m, input int hold, input string tag);
    logic [SZ*DW-1:0] ed, d0;
    logic [LW-1:0] el, l0;
    int k;
    model(p, zz, m, ed, el);
    k = 0;
    while (!in_ready && k < 20) begin @(negedge clk); k++; end
    chk({tag, " in_ready"}, 64'(in_ready), 64'(1));
    predict_value = p; z_in = zz; mode_in = m; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    predict_value = SZ*DW'({$urandom, $urandom});
    z_in = SZ*DW'({$urandom, $urandom});
    mode_in = ~m;
    k = 0;
    do begin @(negedge clk); k++; end while (!out_valid && k < 20);
    chk({tag, " latency"}, 64'(k), 64'(SZ + 1));
    chk({tag, " diff"}, 64'(diff), 64'(ed));
    chk({tag, " loss"}, 64'(loss), 64'(el));
    d0 = diff; l0 = loss;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1;
      @(negedge clk);
      chk({tag, " hold diff"}, 64'(diff), 64'(d0));
      chk({tag, " hold loss"}, 64'(loss), 64'(l0));
      chk({tag, " hold out_valid"}, 64'(out_valid), 64'(1));
      chk({tag, " hold in_ready"}, 64'(in_ready), 64'(0));
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk({tag, " done out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, " done in_ready"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    logic [SZ*DW-1:0] rp, rz, qd[$];
    logic [LW-1:0] ql[$];
    logic rm;
    int last, got, sent;
    #1;
    chk("reset diff", 64'(diff), 64'(0));
    chk("reset loss", 64'(loss), 64'(0));
    chk("reset out_valid", 64'(out_valid), 64'(0));
    chk("reset in_ready", 64'(in_ready), 64'(1));
    @(negedge clk); @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    run_sample({3{16'h0180}}, {3{16'h0180}}, 0, 0, "equal");
    run_sample({16'h0180, 16'h0040, 16'h0040}, {16'h0100, 16'h0040, 16'h0040}, 0, 0, "half m0");
    run_sample({16'h0180, 16'h0040, 16'h0040}, {16'h0100, 16'h0040, 16'h0040}, 1, 0, "half m1");
    run_sample({3{16'h7F00}}, {3{16'h8100}}, 0, 0, "sat pos");
    run_sample({3{16'h8100}}, {3{16'h7F00}}, 1, 0, "sat neg");
    run_sample({16'h0100, 16'h0000, 16'hFF00}, {16'h0000, 16'h0000, 16'h0000}, 1, 5, "stall");
    for (int r = 0; r < 6; r++) begin
      rp = SZ*DW'({$urandom, $urandom});
      rz = SZ*DW'({$urandom, $urandom});
      run_sample(rp, rz, 1'($urandom), 0, "random");
    end
    // reset pulse two cycles after a transfer
    while (!in_ready) @(negedge clk);
    predict_value = {16'h0300, 16'h0100, 16'h0000};
    z_in = '0; mode_in = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    chk("pre-reset diff nonzero", 64'(diff != 0), 64'(1));
    reset_n = 0;
    #1;
    chk("async diff", 64'(diff), 64'(0));
    chk("async loss", 64'(loss), 64'(0));
    chk("async out_valid", 64'(out_valid), 64'(0));
    chk("async in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    reset_n = 1;
    got = 0;
    for (int c = 0; c < 6; c++) begin @(negedge clk); got += int'(out_valid); end
    chk("no output after reset", 64'(got), 64'(0));
    run_sample({16'h0200, 16'hFE00, 16'h0001}, {16'h0100, 16'h0100, 16'h0000}, 0, 1, "post reset");
    // back-to-back stream with out_ready held high
    out_ready = 1; last = -1; got = 0; sent = 0;
    for (int c = 0; c < 200 && got < 6; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (qd.size() == 0) chk("stream unexpected result", 64'(1), 64'(0));
        else begin
          chk("stream diff", 64'(diff), 64'(qd.pop_front()));
          chk("stream loss", 64'(loss), 64'(ql.pop_front()));
        end
        if (last >= 0) chk("stream spacing", 64'(c - last), 64'(SZ + 2));
        last = c; got++;
      end
      if (in_ready && sent < 6) begin
        logic [SZ*DW-1:0] d;
        logic [LW-1:0] l;
        rp = SZ*DW'({$urandom, $urandom});
        rz = SZ*DW'({$urandom, $urandom});
        rm = 1'(sent);
        model(rp, rz, rm, d, l);
        qd.push_back(d); ql.push_back(l);
        predict_value = rp; z_in = rz; mode_in = rm; in_valid = 1; sent++;
      end else if (sent >= 6) in_valid = 0;
    end
    chk("stream count", 64'(got), 64'(6));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cost_grad_engine.md
COST_GRAD_ENGINE -- requirements
Module: cost_grad_engine

Interface
REQ-001 SHALL have parameter size, default 3: number of output channels per sample.
REQ-002 SHALL have parameter data_size, default 16: element width, signed fixed-point, data_size/2 fraction bits.
REQ-003 SHALL have parameter loss_size, default data_size+$clog2(size)+1: loss accumulator width.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 predict_value  input  size*data_size  predictions; channel i at bits [(size-i)*data_size-1 -: data_size].
REQ-007 z  input  size*data_size  targets, same packing.
REQ-008 mode  input  1  0 = squared-error gradient, 1 = absolute-error (sign) gradient.
REQ-009 in_valid / in_ready  input / output  1  sample handshake.
REQ-010 diff  output  size*data_size  per-channel gradient, same packing.
REQ-011 loss  output  loss_size  sum of per-channel squared errors, same fraction bits.
REQ-012 out_valid / out_ready  output / input  1  result handshake.

Function
REQ-013 SHALL use states IDLE, COMPUTE, HOLD.
REQ-014 in_ready SHALL be 1 only in IDLE; a transfer occurs when in_valid && in_ready at a rising edge.
REQ-015 On transfer SHALL register predict_value, z and mode, clear the channel index and the loss accumulator, and enter COMPUTE.
REQ-016 In COMPUTE SHALL process exactly one channel per cycle, index 0 to size-1, then enter HOLD; input changes after the transfer SHALL have no effect.
REQ-017 Per channel: e = sat(p - z); mode 0 grad = sat(-2*e); mode 1 grad = +1.0 if e<0, -1.0 if e>0, 0 if e==0.
REQ-018 Per channel: sq = sat((e*e) >> data_size/2) to data_size bits; loss += sq, saturating at the loss_size signed maximum.
REQ-019 sat() SHALL clamp to the signed data_size range (0x7FFF / 0x8000 for 16 bits); no wrap-around anywhere.
REQ-020 out_valid SHALL be 1 exactly in HOLD; a transfer at cycle T SHALL give out_valid from cycle T+size+1.
REQ-021 While out_valid && !out_ready, diff and loss SHALL hold stable.
REQ-022 When out_valid && out_ready, SHALL return to IDLE; in_ready rises the next cycle; no same-cycle re-accept.
REQ-023 diff channels not yet computed in COMPUTE SHALL read 0; diff and loss are valid only while out_valid.

Reset
REQ-024 reset_n low SHALL immediately force IDLE, diff=0, loss=0, out_valid=0, channel index 0, regardless of clk.
REQ-025 Reset mid-COMPUTE or mid-HOLD SHALL discard the sample with no partial output; after release in_ready=1 on the first edge.

Structure
REQ-026 Saturating sub/mult/add helpers and the state typedef SHALL live in the shared package gdo, alongside gdo_sub and gdo_mult.
REQ-027 Per-channel arithmetic (e, grad, sq) SHALL be one combinational sub-module cost_grad_lane, instantiated once and time-shared across channels.

Verification (size=3, data_size=16, Q8.8)
REQ-028 Reset then p=z=0x0180 on all channels, mode 0 -> diff=0, loss=0, out_valid at T+4.
REQ-029 p ch0=0x0180, z ch0=0x0100, others equal, mode 0 -> diff ch0=0xFF00, loss=0x0040; mode 1 -> diff ch0=0xFF00.
REQ-030 p=0x7F00, z=0x8100 on all channels, mode 0 -> each e=0x7FFF, diff=0x8000 per channel, loss=0x17FFD.
REQ-031 out_ready held low 5 cycles in HOLD -> diff and loss stable, in_ready=0, a new in_valid is ignored.
REQ-032 reset_n pulsed low in cycle T+2 -> outputs 0 immediately, no out_valid; the next sample computes correctly.
REQ-033 Back-to-back samples with out_ready=1 -> one result per size+2 cycles, in input order, mode latched per sample.
